// File: rtl/hex_display.sv
// Hex output stage: time-multiplexed 8-digit common-anode seven-segment driver with frame-synchronous snapshot.
// Optional leading-zero blanking is enabled by defining HEX_DISPLAY_LZB_EN.
module hex_display #(
    parameter int SCAN_DIV   = 100000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        hold_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int             CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [2:0]     IDX_MAX  = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]     DIG_MASK = 8'((9'd1 << NUM_DIGITS) - 9'd1);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   snap_q, snap_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick_s;
    logic          idx_ok_s;
    logic          blank_s;
    logic [31:0]   upper_s;

    // Next-state for the prescaler, digit index, snapshot and registered display outputs.
    always_comb begin
        tick_s   = (cnt_q == CNT_MAX);
        idx_ok_s = DIG_MASK[idx_q];
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        snap_d   = snap_q;

        if (tick_s) begin
            cnt_d = '0;
            if ((idx_q == IDX_MAX) || !idx_ok_s) begin
                idx_d = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Snapshot only at the last slot of a frame, so a frame never mixes two values.
        if (tick_s && (idx_q == IDX_MAX) && !hold_i) begin
            snap_d = data_i;
        end else begin
            snap_d = snap_q;
        end

        upper_s = snap_q >> {idx_q, 2'b00};
`ifdef HEX_DISPLAY_LZB_EN
        blank_s = (idx_q != 3'd0) && (upper_s == 32'd0);
`else
        blank_s = 1'b0;
`endif

        if (!idx_ok_s || blank_s) begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
        end else begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = seg_decode(upper_s[3:0]);
        end

        if ((idx_q == 3'd0) && hold_i) begin
            dp_d = 1'b0;
        end else begin
            dp_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset to a dark display.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            snap_q <= 32'd0;
            an_q   <= 8'hFF;
            seg_q  <= 7'h7F;
            dp_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: doc/hex_display.md
# hex_display

Output stage of the CYBERcobra core: consumes the 32-bit `out_o` word and drives a time-multiplexed 8-digit common-anode seven-segment display as hexadecimal. A prescaler sets the per-digit dwell time. A frame-synchronous snapshot register stops digits from showing parts of two different values while `data_i` changes. All display outputs are registered.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot; legal range ≥ 2.
- `NUM_DIGITS`, default 8: number of scanned digits, 1..8. Digit k shows `data_i[4k+3:4k]`.
- `clk_i`  input  1  system clock; all state is updated on its rising edge.
- `rst_i`  input  1  reset; synchronous and active-high.
- `data_i`  input  32  value to display; connected to core `out_o`.
- `hold_i`  input  1  when high, the snapshot is frozen and the display keeps its current value.
- `an_o`  output  8  digit anodes, active-low. Bit k selects digit k. Bits ≥ NUM_DIGITS are held at 1.
- `seg_o`  output  7  segment cathodes, active-low. Bit 0 = a, bit 6 = g.
- `dp_o`  output  1  decimal point, active-low.

## Operation
- **Prescaler `cnt`:** counts 0..SCAN_DIV-1, then wraps to 0. `tick` is asserted when `cnt` == SCAN_DIV-1.
- **Digit index `idx`:** advances on `tick` and wraps from NUM_DIGITS-1 to 0. With NUM_DIGITS=1, `idx` stays at 0.
- **Frame boundary:** a `tick` with `idx` == NUM_DIGITS-1.
  - At a frame boundary with `hold_i`=0, `snap` is loaded with `data_i`.
  - With `hold_i`=1, `snap` keeps its value.
  - `snap` is never loaded mid-frame.
- **Registered outputs, every cycle:**
  - `an_o`: the bit for the current `idx` is 0; all other bits are 1.
  - `seg_o` = decode(`snap[4*idx+3 : 4*idx]`).
  - `dp_o` = 0 only when `idx`==0 and `hold_i`=1; this is the freeze indicator. Otherwise `dp_o` = 1.
- **Decode table, active-low, {g..a}:**
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- **Reset:**
  - `cnt`=0, `idx`=0, `snap`=0.
  - `an_o`=8'hFF, `seg_o`=7'h7F, `dp_o`=1, so the display is dark during reset.
- **Reset mid-frame:** state returns to the reset values on the same edge, and the scan restarts at digit 0.
- **Unused index values:** none are reachable. If `idx` ≥ NUM_DIGITS occurs, the outputs are all-dark.

## Timing
- **Output latency:** outputs reflect `idx`/`snap` one cycle after they change.
  - First cycle after `rst_i` falls: outputs are still dark.
  - Next edge: digit 0 is lit.
- **Dwell:** each digit is lit for exactly SCAN_DIV cycles. One frame is NUM_DIGITS×SCAN_DIV cycles.
- **Data latency:** a `data_i` change is captured at the next frame boundary and appears on digit 0 one cycle later. Worst case is NUM_DIGITS×SCAN_DIV+1 cycles.
- **`hold_i` timing:** `hold_i` is sampled only at the frame-boundary edge for snapshot purposes. For `dp_o` it is sampled every cycle.
- **Simultaneous `hold_i` rising and frame boundary:** the hold wins and `snap` is not loaded.
- **Counter widths:**
  - `cnt` is $clog2(SCAN_DIV) bits.
  - `idx` is 3 bits.
  - No overflow is possible because both counters wrap explicitly.

## Configuration
- Macro `HEX_DISPLAY_LZB_EN` controls leading-zero blanking.
- **Defined:**
  - Digit k > 0 is blanked (`an_o` bit = 1, `seg_o`=7'h7F) when `snap[31:4k]` == 0, i.e. it lies above the most significant nonzero nibble.
  - Digit 0 is always shown.
  - A blanked slot still consumes its SCAN_DIV dwell, so the scan period is unchanged.
  - The blank decision uses the registered `snap`, with the same one-cycle output latency.
- **Undefined:** all NUM_DIGITS digits are always shown, including leading zeros.

## Test plan
- **Reset:** SCAN_DIV=4; hold `rst_i` for 3 cycles, then release.
  - During reset: `an_o`=FF, `seg_o`=7F, `dp_o`=1.
  - One cycle after release: outputs still dark.
  - Next cycle: `an_o`=FE, `seg_o`=40.
- **Scan order:** SCAN_DIV=4, `data_i`=32'h76543210 held.
  - First frame shows 0 (`snap` reset value).
  - From the second frame, `an_o` steps FE, FD, FB…7F, each for 4 cycles.
  - `seg_o` steps 40, 79, 24, 30, 19, 12, 02, 78.
- **No tearing:** change `data_i` to 32'hFFFFFFFF while digit 3 is lit.
  - Digits 4–7 of the current frame still show the old value.
  - In the next frame, every digit shows `seg_o`=0E.
- **Hold:** set `hold_i`=1 with `snap`=32'h89ABCDEF, then drive `data_i`=0 for 3 frames.
  - Display stays 89ABCDEF.
  - `dp_o`=0 exactly while digit 0 is lit.
  - Release `hold_i`: the next frame shows 0s.
- **Reset mid-frame:** assert `rst_i` while digit 5 is lit.
  - Next edge: outputs dark and `snap`=0.
  - After release, the scan restarts at digit 0.
- **`HEX_DISPLAY_LZB_EN` defined:** `data_i`=32'h00000A05.
  - Digits 3–7 are dark while their slot elapses.
  - Digits 0–2 show 05 → 12, 0 → 40, A → 08.
  - With `data_i`=0: only digit 0 is lit, showing 40.
